i2c_target_regs: RTL and testbench

- I2C target (slave) endpoint: the far end of the bus driven by the team's AXI-Lite I2C master.
- Decodes START/STOP, matches a 7-bit address, ACKs, and bridges bytes onto a simple synchronous register port with an auto-incrementing register pointer.
- Used as a bus-functional peer in the I2C subsystem and as a real register-access target in designs.
- No clock stretching; SCL is input-only.

---
 rtl/i2c_target_regs.sv | 219 +++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target endpoint: START/STOP decode, 7-bit address match, and a byte bridge
// onto a synchronous register port with an auto-incrementing register pointer.
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR    = 7'h50,
  parameter int         REG_ADDR_WIDTH = 8,
  parameter int         SYNC_STAGES    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      scl_pad_i,
  input  logic                      sda_pad_i,
  output logic                      sda_pad_o,
  output logic                      sda_padoen_o,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr_o,
  output logic [7:0]                reg_wdata_o,
  output logic                      reg_we_o,
  output logic                      reg_re_o,
  input  logic [7:0]                reg_rdata_i,
  output logic                      busy_o
);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_PTR       = 4'd3;
  localparam logic [3:0] ST_PTR_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RDATA_ACK = 4'd8;

  logic [SYNC_STAGES-1:0]    scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0]    sda_sync_q, sda_sync_d;
  logic                      scl_prev_q, scl_prev_d;
  logic                      sda_prev_q, sda_prev_d;
  logic [3:0]                state_q, state_d;
  logic [3:0]                bit_cnt_q, bit_cnt_d;
  logic [7:0]                shreg_q, shreg_d;
  logic                      rw_q, rw_d;
  logic [REG_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [7:0]                wdata_q, wdata_d;
  logic                      we_q, we_d;
  logic                      re_q, re_d;
  logic                      oen_q, oen_d;
  logic                      busy_q, busy_d;

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  // SCL must be high in both samples so a data change near an SCL edge is not mistaken for START/STOP.
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_pad_i};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_pad_i};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    rw_d       = rw_q;
    ptr_d      = ptr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    oen_d      = oen_q;
    busy_d     = busy_q;

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      oen_d     = 1'b1;
    end else if (stop_det) begin
      state_d = ST_IDLE;
      oen_d   = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shreg_d   = {shreg_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            if (state_q == ST_ADDR) begin
              if (shreg_q[7:1] == TARGET_ADDR) begin
                oen_d   = 1'b0;
                rw_d    = shreg_q[0];
                busy_d  = 1'b1;
                state_d = ST_ADDR_ACK;
              end else begin
                state_d = ST_IDLE;
              end
            end else if (state_q == ST_PTR) begin
              ptr_d   = REG_ADDR_WIDTH'(shreg_q);
              oen_d   = 1'b0;
              state_d = ST_PTR_ACK;
            end else begin
              we_d    = 1'b1;
              wdata_d = shreg_q;
              oen_d   = 1'b0;
              state_d = ST_WDATA_ACK;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            oen_d     = 1'b1;
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              re_d    = 1'b1;
              state_d = ST_RDATA;
            end else begin
              state_d = ST_PTR;
            end
          end
        end
        ST_PTR_ACK: begin
          if (scl_fall) begin
            oen_d     = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = ST_WDATA;
          end
        end
        ST_WDATA_ACK: begin
          if (scl_fall) begin
            oen_d     = 1'b1;
            bit_cnt_d = 4'd0;
            ptr_d     = ptr_q + REG_ADDR_WIDTH'(1);
            state_d   = ST_WDATA;
          end
        end
        ST_RDATA: begin
          // The cycle after the read strobe carries the register data; drive its MSB immediately.
          if (re_q) begin
            shreg_d = reg_rdata_i;
            oen_d   = reg_rdata_i[7];
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              oen_d     = 1'b1;
              bit_cnt_d = 4'd0;
              state_d   = ST_RDATA_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
              shreg_d   = {shreg_q[6:0], 1'b0};
              oen_d     = shreg_q[6];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              ptr_d = ptr_q + REG_ADDR_WIDTH'(1);
            end
          end else if (scl_fall) begin
            re_d      = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = ST_RDATA;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      shreg_q    <= 8'd0;
      rw_q       <= 1'b0;
      ptr_q      <= '0;
      wdata_q    <= 8'd0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      oen_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      rw_q       <= rw_d;
      ptr_q      <= ptr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
      oen_q      <= oen_d;
      busy_q     <= busy_d;
    end
  end

  // Reset releases SDA combinationally so a held ACK never outlives the reset cycle.
  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = oen_q | rst_i;
  assign reg_addr_o   = ptr_q;
  assign reg_wdata_o  = wdata_q;
  assign reg_we_o     = we_q;
  assign reg_re_o     = re_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-level I2C master, transaction-level model of the
// register bridge (pointer arithmetic, expected strobes and read bytes).
module tb_i2c_target_regs;
  localparam int Q = 5;
  localparam logic [6:0] TADDR = 7'h50;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_line;
  logic       sda_pad_o, sda_padoen_o;
  logic [7:0] reg_addr_o, reg_wdata_o, reg_rdata_i;
  logic       reg_we_o, reg_re_o, busy_o;

  int n_checks = 0;
  int n_errors = 0;
  int model_ptr = 0;
  int obs_we_addr[$], obs_we_data[$], obs_re_addr[$];
  int exp_we_addr[$], exp_we_data[$], exp_re_addr[$];

  always #5 clk = ~clk;

  // Open-drain bus: either side can pull low.
  assign sda_line    = m_sda & (sda_padoen_o | sda_pad_o);
  assign reg_rdata_i = reg_addr_o ^ 8'h5A;

  i2c_target_regs #(.TARGET_ADDR(TADDR), .REG_ADDR_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .scl_pad_i(m_scl), .sda_pad_i(sda_line),
    .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o), .reg_addr_o(reg_addr_o),
    .reg_wdata_o(reg_wdata_o), .reg_we_o(reg_we_o), .reg_re_o(reg_re_o),
    .reg_rdata_i(reg_rdata_i), .busy_o(busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_i) begin
      if (reg_we_o || reg_re_o) check("strobe_excl", {31'd0, reg_we_o & reg_re_o}, 32'd0);
      if (reg_we_o) begin
        obs_we_addr.push_back(int'(reg_addr_o));
        obs_we_data.push_back(int'(reg_wdata_o));
      end
      if (reg_re_o) obs_re_addr.push_back(int'(reg_addr_o));
    end
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clock_bit(input logic drv, output logic seen);
    m_sda = drv;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    seen = sda_line;
    wait_q();
    m_scl = 1'b0;
    wait_q();
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic read_byte(input logic ack_it, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    clock_bit(~ack_it, s);
  endtask

  task automatic compare_strobes();
    check("we_count", obs_we_addr.size(), exp_we_addr.size());
    for (int i = 0; i < obs_we_addr.size() && i < exp_we_addr.size(); i++) begin
      check("we_addr", obs_we_addr[i], exp_we_addr[i]);
      check("we_data", obs_we_data[i], exp_we_data[i]);
    end
    check("re_count", obs_re_addr.size(), exp_re_addr.size());
    for (int i = 0; i < obs_re_addr.size() && i < exp_re_addr.size(); i++)
      check("re_addr", obs_re_addr[i], exp_re_addr[i]);
    obs_we_addr.delete(); obs_we_data.delete(); obs_re_addr.delete();
    exp_we_addr.delete(); exp_we_data.delete(); exp_re_addr.delete();
  endtask

  // Write transaction: address, pointer byte, then n data bytes taken MSB-first from data.
  task automatic txn_write(input logic [6:0] a7, input logic [7:0] ptr, input int n,
                           input logic [31:0] data);
    logic ack;
    logic match;
    logic [7:0] d;
    match = (a7 == TADDR);
    $display("txn write: addr7=0x%0h ptr=0x%0h n=%0d data=0x%08h", a7, ptr, n, data);
    bus_start();
    write_byte({a7, 1'b0}, ack);
    check("addr_ack", ack, match);
    if (match) begin
      check("busy_match", busy_o, 1);
      write_byte(ptr, ack);
      check("ptr_ack", ack, 1);
      model_ptr = ptr;
      for (int i = 0; i < n; i++) begin
        d = data[31-8*i -: 8];
        write_byte(d, ack);
        check("data_ack", ack, 1);
        exp_we_addr.push_back(model_ptr);
        exp_we_data.push_back(int'(d));
        model_ptr = (model_ptr + 1) % 256;
      end
    end else begin
      check("busy_nomatch", busy_o, 0);
    end
    bus_stop();
    check("busy_stop", busy_o, 0);
    check("sda_rel_stop", sda_padoen_o, 1);
    compare_strobes();
  endtask

  // Read transaction, optionally preceded by a pointer write and repeated START.
  task automatic txn_read(input logic set_ptr, input logic [7:0] ptr, input int n);
    logic ack;
    logic [7:0] d;
    $display("txn read: set_ptr=%0d ptr=0x%0h n=%0d", set_ptr, set_ptr ? ptr : 8'(model_ptr), n);
    bus_start();
    if (set_ptr) begin
      write_byte({TADDR, 1'b0}, ack);
      check("rd_waddr_ack", ack, 1);
      write_byte(ptr, ack);
      check("rd_ptr_ack", ack, 1);
      model_ptr = ptr;
      bus_start();
    end
    write_byte({TADDR, 1'b1}, ack);
    check("rd_addr_ack", ack, 1);
    for (int i = 0; i < n; i++) begin
      exp_re_addr.push_back(model_ptr);
      read_byte(i < n - 1, d);
      check("rdata", d, (model_ptr ^ 8'h5A) & 8'hFF);
      if (i < n - 1) model_ptr = (model_ptr + 1) % 256;
    end
    check("busy_nack", busy_o, 0);
    bus_stop();
    check("busy_stop", busy_o, 0);
    compare_strobes();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_oen"}, sda_padoen_o, 1);
    check({tag, "_pad_o"}, sda_pad_o, 0);
    check({tag, "_we"}, reg_we_o, 0);
    check({tag, "_re"}, reg_re_o, 0);
    check({tag, "_addr"}, reg_addr_o, 0);
    check({tag, "_wdata"}, reg_wdata_o, 0);
    check({tag, "_busy"}, busy_o, 0);
  endtask

  initial begin
    logic ack, s;
    int kind;
    logic [6:0] bad;
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    @(negedge clk);
    rst_i = 1'b0;
    wait_q();

    txn_write(TADDR, 8'h10, 2, 32'h1122_0000);
    txn_read(1'b1, 8'h20, 3);
    txn_write(7'h51, 8'h00, 0, 32'h0);
    txn_write(TADDR, 8'hFF, 2, 32'h0102_0000);

    $display("txn stop mid-wdata: ptr=0x30");
    bus_start();
    write_byte({TADDR, 1'b0}, ack);
    check("mid_addr_ack", ack, 1);
    write_byte(8'h30, ack);
    check("mid_ptr_ack", ack, 1);
    model_ptr = 8'h30;
    for (int i = 0; i < 4; i++) clock_bit(1'($urandom_range(0, 1)), s);
    bus_stop();
    check("mid_busy", busy_o, 0);
    check("mid_oen", sda_padoen_o, 1);
    compare_strobes();
    txn_write(TADDR, 8'h30, 1, 32'hC300_0000);

    $display("txn reset during ACK");
    bus_start();
    for (int i = 7; i >= 0; i--) clock_bit(8'hA0 >> i, s);
    check("ack_driven", sda_padoen_o, 0);
    check("ack_busy", busy_o, 1);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("rst1");
    m_sda = 1'b1;
    m_scl = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    model_ptr = 0;
    wait_q();
    compare_strobes();
    txn_write(TADDR, 8'h44, 2, 32'hA55A_0000);

    for (int t = 0; t < 20; t++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: txn_write(TADDR, 8'($urandom), $urandom_range(1, 4), $urandom);
        1: txn_read(1'b1, 8'($urandom), $urandom_range(1, 3));
        2: txn_read(1'b0, 8'h00, $urandom_range(1, 3));
        default: begin
          bad = 7'($urandom);
          if (bad == TADDR) bad = bad ^ 7'h01;
          txn_write(bad, 8'h00, 0, 32'h0);
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
